// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store sequencer: access types (same as the
// control decoder's memType field), FSM states and access-size helper.
package lsu_pkg;

   localparam logic [1:0] MEM_WORD    = 2'b00;
   localparam logic [1:0] MEM_BYTE    = 2'b01;
   localparam logic [1:0] MEM_HALF    = 2'b10;
   localparam logic [1:0] MEM_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      BEAT0 = 2'b01,
      BEAT1 = 2'b10,
      FAULT = 2'b11
   } lsu_state_t;

   // Access size in bytes; illegal types report 0 so they never enable a lane.
   function automatic logic [2:0] access_size(input logic [1:0] mem_type);
      logic [2:0] size;
      case (mem_type)
         MEM_BYTE: size = 3'd1;
         MEM_HALF: size = 3'd2;
         MEM_WORD: size = 3'd4;
         default:  size = 3'd0;
      endcase
      return size;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and write lanes across a 64-bit
// two-word window, word-crossing detection, and load extraction/extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  off_i,
   input  logic [1:0]  type_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_lo_i,
   input  logic [31:0] rdata_hi_i,
   output logic [7:0]  be64_o,
   output logic [63:0] wlanes_o,
   output logic        split_o,
   output logic [31:0] load_data_o
);

   logic [2:0]  size;
   logic [7:0]  be_mask;
   logic [5:0]  shamt;
   logic [31:0] shifted;

   always_comb begin
      size    = access_size(type_i);
      shamt   = {1'b0, off_i, 3'b000};
      be_mask = 8'h00;
      case (size)
         3'd1:    be_mask = 8'h01;
         3'd2:    be_mask = 8'h03;
         3'd4:    be_mask = 8'h0F;
         default: be_mask = 8'h00;
      endcase

      be64_o   = be_mask << off_i;
      wlanes_o = {32'b0, wdata_i} << shamt;
      split_o  = ({2'b00, off_i} + {1'b0, size}) > 4'd4;

      // Only the low word of the realigned pair can hold the loaded value.
      shifted = 32'({rdata_hi_i, rdata_lo_i} >> shamt);

      case (type_i)
         MEM_BYTE: load_data_o = unsigned_i ? {24'b0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
         MEM_HALF: load_data_o = unsigned_i ? {16'b0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
         default:  load_data_o = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one request at a time, 1-2 bus beats, registered
// response one cycle after the last beat; stalls the pipe while busy.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_write_i,
   input  logic [1:0]            req_type_i,
   input  logic                  req_unsigned_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [31:0]           req_wdata_i,
   output logic                  rsp_valid_o,
   output logic [31:0]           rsp_rdata_o,
   output logic                  rsp_fault_o,
   output logic                  stall_o,
   output logic                  mem_valid_o,
   input  logic                  mem_ready_i,
   output logic                  mem_write_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [31:0]           mem_wdata_o,
   output logic [3:0]            mem_be_o,
   input  logic [31:0]           mem_rdata_i
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   lsu_state_t            state_q, state_d;
   logic                  write_q, write_d;
   logic [1:0]            type_q, type_d;
   logic                  unsigned_q, unsigned_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rd_lo_q, rd_lo_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_fault_q, rsp_fault_d;
   logic [31:0]           rsp_rdata_q, rsp_rdata_d;

   logic [7:0]            be64;
   logic [63:0]           wlanes;
   logic                  split;
   logic [31:0]           load_data;
   logic [31:0]           rdata_lo;
   logic [ADDR_WIDTH-1:0] word_addr;

   // A non-split load completes in BEAT0, so the low word comes straight off the bus.
   assign rdata_lo  = (state_q == BEAT0) ? mem_rdata_i : rd_lo_q;
   assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

   lsu_align u_align (
      .off_i       (addr_q[1:0]),
      .type_i      (type_q),
      .unsigned_i  (unsigned_q),
      .wdata_i     (wdata_q),
      .rdata_lo_i  (rdata_lo),
      .rdata_hi_i  (mem_rdata_i),
      .be64_o      (be64),
      .wlanes_o    (wlanes),
      .split_o     (split),
      .load_data_o (load_data)
   );

   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      type_d      = type_q;
      unsigned_d  = unsigned_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rd_lo_d     = rd_lo_q;
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      rsp_fault_d = 1'b0;
      rsp_rdata_d = 32'b0;
      mem_valid_o = 1'b0;
      mem_write_o = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = 32'b0;
      mem_be_o    = 4'b0;
      req_ready_o = (state_q == IDLE);

      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               write_d    = req_write_i;
               type_d     = req_type_i;
               unsigned_d = req_unsigned_i;
               addr_d     = req_addr_i;
               wdata_d    = req_wdata_i;
               cnt_d      = '0;
               state_d    = (req_type_i == MEM_ILLEGAL) ? FAULT : BEAT0;
            end
         end

         BEAT0: begin
            mem_valid_o = 1'b1;
            mem_write_o = write_q;
            mem_addr_o  = word_addr;
            mem_wdata_o = wlanes[31:0];
            mem_be_o    = be64[3:0];
            if (mem_ready_i) begin
               rd_lo_d = mem_rdata_i;
               cnt_d   = '0;
               if (split) begin
                  state_d = BEAT1;
               end else begin
                  state_d     = IDLE;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = write_q ? 32'b0 : load_data;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         BEAT1: begin
            mem_valid_o = 1'b1;
            mem_write_o = write_q;
            mem_addr_o  = word_addr + ADDR_WIDTH'(4);
            mem_wdata_o = wlanes[63:32];
            mem_be_o    = be64[7:4];
            if (mem_ready_i) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = write_q ? 32'b0 : load_data;
            end else if (cnt_q == CNT_LAST) begin
               // Low half of a split store may already be committed; that is tolerated.
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         FAULT: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         write_q     <= 1'b0;
         type_q      <= MEM_WORD;
         unsigned_q  <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 32'b0;
         rd_lo_q     <= 32'b0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_fault_q <= 1'b0;
         rsp_rdata_q <= 32'b0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         type_q      <= type_d;
         unsigned_q  <= unsigned_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rd_lo_q     <= rd_lo_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_fault_q <= rsp_fault_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_fault_o = rsp_fault_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign stall_o     = (state_q != IDLE) || (req_valid_i && req_ready_o);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: inputs driven and outputs sampled around the
// falling edge, expectations hand-computed per vector.
module tb_lsu_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_write_i;
   logic [1:0]  req_type_i;
   logic        req_unsigned_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_fault_o;
   logic        stall_o;
   logic        mem_valid_o;
   logic        mem_ready_i;
   logic        mem_write_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_rdata_i;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   lsu_ctrl #(
      .ADDR_WIDTH     (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_write_i    (req_write_i),
      .req_type_i     (req_type_i),
      .req_unsigned_i (req_unsigned_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_fault_o    (rsp_fault_o),
      .stall_o        (stall_o),
      .mem_valid_o    (mem_valid_o),
      .mem_ready_i    (mem_ready_i),
      .mem_write_o    (mem_write_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_be_o       (mem_be_o),
      .mem_rdata_i    (mem_rdata_i)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // Offer one request at a falling edge; returns one cycle later (accepted).
   task automatic issue(input logic w, input logic [1:0] t, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
      req_valid_i    = 1'b1;
      req_write_i    = w;
      req_type_i     = t;
      req_unsigned_i = u;
      req_addr_i     = a;
      req_wdata_i    = d;
      #1;
      check("req_ready", 32'(req_ready_o), 32'd1);
      check("stall_accept", 32'(stall_o), 32'd1);
      @(negedge clk_i);
      req_valid_i = 1'b0;
   endtask

   // Hold ready low for 'waits' cycles, then complete the beat with 'rd'.
   task automatic beat(input string tag, input logic [31:0] ea, input logic [3:0] ebe,
                       input logic [31:0] ewd, input logic ew, input logic [31:0] rd,
                       input int waits);
      for (int i = 0; i < waits; i++) begin
         mem_ready_i = 1'b0;
         #1;
         check({tag, "_wait_vld"}, 32'(mem_valid_o), 32'd1);
         check({tag, "_wait_addr"}, mem_addr_o, ea);
         check({tag, "_wait_rsp"}, 32'(rsp_valid_o), 32'd0);
         @(negedge clk_i);
      end
      mem_ready_i = 1'b1;
      mem_rdata_i = rd;
      #1;
      check({tag, "_vld"}, 32'(mem_valid_o), 32'd1);
      check({tag, "_addr"}, mem_addr_o, ea);
      check({tag, "_be"}, 32'(mem_be_o), 32'(ebe));
      check({tag, "_wdata"}, mem_wdata_o, ewd);
      check({tag, "_write"}, 32'(mem_write_o), 32'(ew));
      check({tag, "_stall"}, 32'(stall_o), 32'd1);
      check({tag, "_no_rsp"}, 32'(rsp_valid_o), 32'd0);
      @(negedge clk_i);
      mem_ready_i = 1'b0;
      mem_rdata_i = 32'h0;
   endtask

   task automatic expect_rsp(input string tag, input logic [31:0] rd, input logic fault);
      #1;
      check({tag, "_rsp_vld"}, 32'(rsp_valid_o), 32'd1);
      check({tag, "_rsp_rdata"}, rsp_rdata_o, rd);
      check({tag, "_rsp_fault"}, 32'(rsp_fault_o), 32'(fault));
      check({tag, "_rsp_membus"}, 32'(mem_valid_o), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni         = 1'b0;
      req_valid_i    = 1'b0;
      req_write_i    = 1'b0;
      req_type_i     = 2'b00;
      req_unsigned_i = 1'b0;
      req_addr_i     = 32'h0;
      req_wdata_i    = 32'h0;
      mem_ready_i    = 1'b0;
      mem_rdata_i    = 32'h0;
      repeat (2) @(negedge clk_i);
      check("rst_req_ready", 32'(req_ready_o), 32'd1);
      check("rst_rsp", {29'b0, rsp_valid_o, rsp_fault_o, stall_o}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata_o, 32'h0);
      check("rst_mem_ctl", {26'b0, mem_valid_o, mem_write_o, mem_be_o}, 32'd0);
      check("rst_mem_addr", mem_addr_o, 32'h0);
      check("rst_mem_wdata", mem_wdata_o, 32'h0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Aligned word load, zero wait: response two cycles after accept.
      issue(1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0);
      beat("lw", 32'h100, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF, 0);
      expect_rsp("lw", 32'hDEAD_BEEF, 1'b0);

      // Back-to-back accept while the previous response is on the port.
      issue(1'b0, 2'b01, 1'b0, 32'h0000_0203, 32'h0);
      beat("lb", 32'h200, 4'h8, 32'h0, 1'b0, 32'h8000_0000, 0);
      expect_rsp("lb", 32'hFFFF_FF80, 1'b0);

      issue(1'b0, 2'b01, 1'b1, 32'h0000_0203, 32'h0);
      beat("lbu", 32'h200, 4'h8, 32'h0, 1'b0, 32'h8000_0000, 1);
      expect_rsp("lbu", 32'h0000_0080, 1'b0);

      // Split store across 0x100/0x104.
      issue(1'b1, 2'b00, 1'b0, 32'h0000_0102, 32'h1122_3344);
      beat("sw_b0", 32'h100, 4'hC, 32'h3344_0000, 1'b1, 32'h0, 0);
      beat("sw_b1", 32'h104, 4'h3, 32'h0000_1122, 1'b1, 32'h0, 0);
      expect_rsp("sw", 32'h0, 1'b0);

      issue(1'b0, 2'b10, 1'b0, 32'h0000_00FF, 32'h0);
      beat("lh_b0", 32'h0FC, 4'h8, 32'h0, 1'b0, 32'hAB00_0000, 0);
      beat("lh_b1", 32'h100, 4'h1, 32'h0, 1'b0, 32'h0000_00CD, 0);
      expect_rsp("lh", 32'hFFFF_CDAB, 1'b0);

      issue(1'b0, 2'b10, 1'b1, 32'h0000_00FF, 32'h0);
      beat("lhu_b0", 32'h0FC, 4'h8, 32'h0, 1'b0, 32'hAB00_0000, 0);
      beat("lhu_b1", 32'h100, 4'h1, 32'h0, 1'b0, 32'h0000_00CD, 2);
      expect_rsp("lhu", 32'h0000_CDAB, 1'b0);

      // Split word load whose second beat wraps to address 0.
      issue(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFE, 32'h0);
      beat("lwrap_b0", 32'hFFFF_FFFC, 4'hC, 32'h0, 1'b0, 32'h5678_0000, 0);
      beat("lwrap_b1", 32'h0000_0000, 4'h3, 32'h0, 1'b0, 32'h0000_1234, 0);
      expect_rsp("lwrap", 32'h1234_5678, 1'b0);

      @(negedge clk_i);
      #1;
      check("idle_rsp_pulse", 32'(rsp_valid_o), 32'd0);
      check("idle_stall", 32'(stall_o), 32'd0);

      // Illegal access type: no bus beat, fault two cycles after accept.
      @(negedge clk_i);
      issue(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0);
      #1;
      check("ill_no_beat", 32'(mem_valid_o), 32'd0);
      check("ill_stall", 32'(stall_o), 32'd1);
      @(negedge clk_i);
      expect_rsp("ill", 32'h0, 1'b1);

      // Timeout with TIMEOUT_CYCLES=4: valid held four cycles, then fault.
      @(negedge clk_i);
      issue(1'b0, 2'b00, 1'b0, 32'h0000_0040, 32'h0);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("to_vld_held", 32'(mem_valid_o), 32'd1);
         check("to_addr_stable", mem_addr_o, 32'h40);
         @(negedge clk_i);
      end
      expect_rsp("to", 32'h0, 1'b1);

      // Asynchronous reset while the second beat is waiting.
      @(negedge clk_i);
      issue(1'b0, 2'b10, 1'b0, 32'h0000_00FF, 32'h0);
      beat("rst_b0", 32'h0FC, 4'h8, 32'h0, 1'b0, 32'hAB00_0000, 0);
      #1;
      check("rst_b1_vld", 32'(mem_valid_o), 32'd1);
      #1;
      rst_ni = 1'b0;
      #1;
      check("arst_mem_vld", 32'(mem_valid_o), 32'd0);
      check("arst_mem_addr", mem_addr_o, 32'h0);
      check("arst_mem_be", 32'(mem_be_o), 32'd0);
      check("arst_req_ready", 32'(req_ready_o), 32'd1);
      check("arst_stall", 32'(stall_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         #1;
         check("arst_no_rsp", 32'(rsp_valid_o), 32'd0);
      end

      issue(1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'h0);
      beat("post_rst", 32'h020, 4'hF, 32'h0, 1'b0, 32'h0BAD_F00D, 0);
      expect_rsp("post_rst", 32'h0BAD_F00D, 1'b0);

      @(negedge clk_i);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
